// File: rtl/pulse_monitor_pkg.sv
// Shared definitions for the pulse safety monitor.
// Contents:
//   - state_t: monitor FSM states (IDLE / HIGH / LOW)
//   - STAT_*: bit positions inside the monitor_status byte
//   - CNT_W_DEFAULT, SYNC_STAGES_DEFAULT: default parameter values
//   - CNT_MAX: saturation value of a counter at the default width
package pulse_monitor_pkg;

  localparam int CNT_W_DEFAULT       = 32;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int STAT_SHORT = 0;
  localparam int STAT_LONG  = 1;
  localparam int STAT_RATE  = 2;
  localparam int STAT_ANY   = 3;
  localparam int STAT_LEVEL = 4;
  localparam int STAT_HIGH  = 5;
  localparam int STAT_SEEN  = 6;
  localparam int STAT_RSVD  = 7;

endpackage

// File: rtl/pulse_sync.sv
// Synchroniser and edge detector for the asynchronous laser trigger.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   pulse_in  - asynchronous trigger input
//   p_s       - synchronised trigger level
//   rise      - one-cycle pulse on a synchronised low-to-high transition
//   fall      - one-cycle pulse on a synchronised high-to-low transition
// p_s, rise and fall are all registered and mutually aligned, so an edge
// on pulse_in shows up on rise/fall SYNC_STAGES+1 clocks later.
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic p_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES-1:0] fill;
  logic                   armed;
  logic                   level;

  assign level = chain[SYNC_STAGES-1];

  // The chain is flushed to zero by reset, so right after reset its output
  // does not reflect the real input. fill tracks when the chain holds real
  // samples; rise is only accepted once a genuine low has been observed, so
  // a pulse already in flight during reset is never reported as a new rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      fill  <= '0;
      armed <= 1'b0;
      p_s   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pulse_in};
      fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1] && !level) begin
        armed <= 1'b1;
      end
      p_s  <= level;
      rise <= armed & level & ~p_s;
      fall <= ~level & p_s;
    end
  end

endmodule

// File: rtl/pulse_safety_monitor.sv
// Laser trigger safety monitor. Measures the width and rise-to-rise period
// of each trigger pulse in clk cycles, compares them against the limit
// registers and raises sticky fault flags that gate the laser.
// Ports:
//   clk, rst                  - system clock, synchronous active-high reset
//   pulse_in                  - asynchronous laser trigger
//   enable                    - monitor enable
//   clear_fault               - single-cycle clear of the sticky faults
//   pulse_width_lower_limit   - minimum high time (0 = check off)
//   pulse_width_upper_limit   - maximum high time (0 = check off)
//   rate_lower_limit          - minimum rise-to-rise period (0 = check off)
//   fault_short/long/rate     - sticky fault flags
//   safe_out                  - registered enable & no fault
//   last_width, last_period   - last measured width / period
//   monitor_status            - status byte for the I2C status register
module pulse_safety_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             enable,
  input  logic             clear_fault,
  input  logic [CNT_W-1:0] pulse_width_lower_limit,
  input  logic [CNT_W-1:0] pulse_width_upper_limit,
  input  logic [CNT_W-1:0] rate_lower_limit,
  output logic             fault_short,
  output logic             fault_long,
  output logic             fault_rate,
  output logic             safe_out,
  output logic [CNT_W-1:0] last_width,
  output logic [CNT_W-1:0] last_period,
  output logic [7:0]       monitor_status
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic             p_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] wcnt_next;
  logic [CNT_W-1:0] pcnt_next;
  logic             cap_width;
  logic             cap_period;
  logic             set_short;
  logic             set_long;
  logic             set_rate;
  logic             pulse_seen;
  logic             seen_next;
  logic             any_fault;

  pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .p_s      (p_s),
    .rise     (rise),
    .fall     (fall)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT) ? v : v + ONE;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Disabling the monitor parks the FSM in IDLE, and IDLE
  // only leaves on a fresh rise, so enabling mid-pulse waits for the next one.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise) next_state = ST_HIGH;
        ST_HIGH: if (fall) next_state = ST_LOW;
        ST_LOW:  if (rise) next_state = ST_HIGH;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Counter updates, captures and check conditions. The period counter runs
  // in every cycle except the rise that restarts it, which makes rises P
  // clocks apart measure exactly P. A saturated pcnt is all-ones, so it is
  // never below a limit and passes the rate check on its own.
  always_comb begin
    wcnt_next  = wcnt;
    pcnt_next  = pcnt;
    seen_next  = pulse_seen;
    cap_width  = 1'b0;
    cap_period = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    set_rate   = 1'b0;
    if (!enable) begin
      wcnt_next = '0;
      pcnt_next = '0;
      seen_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            wcnt_next = ONE;
            pcnt_next = ONE;
            seen_next = 1'b1;
          end else begin
            wcnt_next = '0;
            pcnt_next = '0;
          end
        end
        ST_HIGH: begin
          pcnt_next = sat_inc(pcnt);
          set_long  = (pulse_width_upper_limit != '0) &&
                      (wcnt > pulse_width_upper_limit);
          if (fall) begin
            cap_width = 1'b1;
            set_short = (pulse_width_lower_limit != '0) &&
                        (wcnt < pulse_width_lower_limit);
          end else begin
            wcnt_next = sat_inc(wcnt);
          end
        end
        ST_LOW: begin
          if (rise) begin
            cap_period = 1'b1;
            set_rate   = (rate_lower_limit != '0) && (pcnt < rate_lower_limit);
            wcnt_next  = ONE;
            pcnt_next  = ONE;
          end else begin
            pcnt_next = sat_inc(pcnt);
          end
        end
        default: begin
          wcnt_next = '0;
          pcnt_next = '0;
        end
      endcase
    end
  end

  // Datapath registers. A fault set beats a simultaneous clear so that a
  // violation can never be lost to a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt        <= '0;
      pcnt        <= '0;
      last_width  <= '0;
      last_period <= '0;
      fault_short <= 1'b0;
      fault_long  <= 1'b0;
      fault_rate  <= 1'b0;
      safe_out    <= 1'b0;
      pulse_seen  <= 1'b0;
    end else begin
      wcnt       <= wcnt_next;
      pcnt       <= pcnt_next;
      pulse_seen <= seen_next;
      if (cap_width)  last_width  <= wcnt;
      if (cap_period) last_period <= pcnt;
      if (set_short)        fault_short <= 1'b1;
      else if (clear_fault) fault_short <= 1'b0;
      if (set_long)         fault_long  <= 1'b1;
      else if (clear_fault) fault_long  <= 1'b0;
      if (set_rate)         fault_rate  <= 1'b1;
      else if (clear_fault) fault_rate  <= 1'b0;
      safe_out <= enable & ~any_fault;
    end
  end

  assign any_fault = fault_short | fault_long | fault_rate;

  // Status byte assembly.
  always_comb begin
    monitor_status             = '0;
    monitor_status[STAT_SHORT] = fault_short;
    monitor_status[STAT_LONG]  = fault_long;
    monitor_status[STAT_RATE]  = fault_rate;
    monitor_status[STAT_ANY]   = any_fault;
    monitor_status[STAT_LEVEL] = p_s;
    monitor_status[STAT_HIGH]  = (state == ST_HIGH);
    monitor_status[STAT_SEEN]  = pulse_seen;
    monitor_status[STAT_RSVD]  = 1'b0;
  end

endmodule

// File: tb/tb_pulse_safety_monitor.sv
// Directed testbench for pulse_safety_monitor. Inputs change 1 ns after a
// rising clock edge and outputs are sampled at the same point, so "after
// N edges" below means N rising edges have been taken since the change.
module tb_pulse_safety_monitor;

  logic        clk;
  logic        rst;
  logic        pulse_in;
  logic        enable;
  logic        clear_fault;
  logic [31:0] lo_lim;
  logic [31:0] hi_lim;
  logic [31:0] rate_lim;
  logic        fault_short;
  logic        fault_long;
  logic        fault_rate;
  logic        safe_out;
  logic [31:0] last_width;
  logic [31:0] last_period;
  logic [7:0]  monitor_status;

  int total = 0;
  int bad   = 0;

  pulse_safety_monitor #(
    .CNT_W       (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .pulse_in                (pulse_in),
    .enable                  (enable),
    .clear_fault             (clear_fault),
    .pulse_width_lower_limit (lo_lim),
    .pulse_width_upper_limit (hi_lim),
    .rate_lower_limit        (rate_lim),
    .fault_short             (fault_short),
    .fault_long              (fault_long),
    .fault_rate              (fault_rate),
    .safe_out                (safe_out),
    .last_width              (last_width),
    .last_period             (last_period),
    .monitor_status          (monitor_status)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold pulse_in at a level for a number of clock edges.
  task automatic applyStimulus(input logic level, input int cycles);
    pulse_in = level;
    tick(cycles);
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst         = 1'b1;
    pulse_in    = 1'b0;
    enable      = 1'b0;
    clear_fault = 1'b0;
    lo_lim      = 32'd0;
    hi_lim      = 32'd0;
    rate_lim    = 32'd0;
    tick(3);

    $display("[TB] reset state");
    checkOutput("rst_safe", {31'd0, safe_out}, 32'd0);
    checkOutput("rst_faults", {29'd0, fault_short, fault_long, fault_rate}, 32'd0);
    checkOutput("rst_width", last_width, 32'd0);
    checkOutput("rst_period", last_period, 32'd0);
    checkOutput("rst_status", {24'd0, monitor_status}, 32'h00);

    rst      = 1'b0;
    enable   = 1'b1;
    lo_lim   = 32'd10;
    hi_lim   = 32'd20;
    rate_lim = 32'd100;
    tick(5);
    checkOutput("en_safe", {31'd0, safe_out}, 32'd1);

    $display("[TB] nominal 15-cycle pulses every 200 cycles");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 15);
      applyStimulus(1'b0, 185);
    end
    checkOutput("nom_width", last_width, 32'd15);
    checkOutput("nom_period", last_period, 32'd200);
    checkOutput("nom_faults", {29'd0, fault_short, fault_long, fault_rate}, 32'd0);
    checkOutput("nom_safe", {31'd0, safe_out}, 32'd1);
    checkOutput("nom_status", {24'd0, monitor_status}, 32'h40);

    $display("[TB] short pulse");
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 3);
    checkOutput("short_at_fall", {31'd0, fault_short}, 32'd0);
    tick(1);
    checkOutput("short_set", {31'd0, fault_short}, 32'd1);
    checkOutput("short_width", last_width, 32'd5);
    checkOutput("short_safe_lag", {31'd0, safe_out}, 32'd1);
    tick(1);
    checkOutput("short_safe_drop", {31'd0, safe_out}, 32'd0);
    tick(3);
    checkOutput("short_status", {24'd0, monitor_status}, 32'h49);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checkOutput("short_clear", {31'd0, fault_short}, 32'd0);
    applyStimulus(1'b0, 150);
    checkOutput("short_safe_back", {31'd0, safe_out}, 32'd1);

    $display("[TB] long pulse");
    applyStimulus(1'b1, 24);
    checkOutput("long_wcnt20", {31'd0, fault_long}, 32'd0);
    applyStimulus(1'b1, 1);
    checkOutput("long_wcnt21", {31'd0, fault_long}, 32'd1);
    applyStimulus(1'b1, 25);
    applyStimulus(1'b0, 150);
    checkOutput("long_width", last_width, 32'd50);
    checkOutput("long_noshort", {31'd0, fault_short}, 32'd0);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 150);
    checkOutput("exact20_long", {31'd0, fault_long}, 32'd0);
    checkOutput("exact20_width", last_width, 32'd20);

    $display("[TB] rate violation");
    enable = 1'b0;
    tick(2);
    checkOutput("dis_safe", {31'd0, safe_out}, 32'd0);
    checkOutput("dis_status", {24'd0, monitor_status}, 32'h00);
    enable = 1'b1;
    tick(2);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 50);
    checkOutput("rate_first_exempt", {31'd0, fault_rate}, 32'd0);
    applyStimulus(1'b1, 10);
    checkOutput("rate_second", {31'd0, fault_rate}, 32'd1);
    checkOutput("rate_period", last_period, 32'd60);
    applyStimulus(1'b0, 50);
    pulse_in = 1'b1;
    tick(3);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checkOutput("rate_set_wins", {31'd0, fault_rate}, 32'd1);
    tick(6);
    applyStimulus(1'b0, 150);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checkOutput("rate_clear", {31'd0, fault_rate}, 32'd0);

    $display("[TB] all checks disabled");
    lo_lim   = 32'd0;
    hi_lim   = 32'd0;
    rate_lim = 32'd0;
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 10);
    checkOutput("off_faults", {29'd0, fault_short, fault_long, fault_rate}, 32'd0);
    checkOutput("off_width", last_width, 32'd40);
    checkOutput("off_period", last_period, 32'd7);

    $display("[TB] enable dropped mid-pulse");
    lo_lim = 32'd10;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 20);
    checkOutput("mid_status_high", {24'd0, monitor_status}, 32'h79);
    enable = 1'b0;
    tick(2);
    checkOutput("mid_dis_safe", {31'd0, safe_out}, 32'd0);
    checkOutput("mid_dis_fault", {31'd0, fault_short}, 32'd1);
    checkOutput("mid_dis_status", {24'd0, monitor_status}, 32'h19);
    enable = 1'b1;
    applyStimulus(1'b1, 10);
    checkOutput("mid_reen_idle", {24'd0, monitor_status}, 32'h19);
    applyStimulus(1'b0, 20);
    checkOutput("mid_reen_width", last_width, 32'd5);

    $display("[TB] reset mid-pulse");
    lo_lim = 32'd0;
    applyStimulus(1'b1, 10);
    rst = 1'b1;
    tick(2);
    checkOutput("midrst_faults", {29'd0, fault_short, fault_long, fault_rate}, 32'd0);
    checkOutput("midrst_safe", {31'd0, safe_out}, 32'd0);
    checkOutput("midrst_width", last_width, 32'd0);
    checkOutput("midrst_period", last_period, 32'd0);
    checkOutput("midrst_status", {24'd0, monitor_status}, 32'h00);
    rst = 1'b0;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 20);
    checkOutput("midrst_unmeasured", last_width, 32'd0);
    checkOutput("midrst_idle", {24'd0, monitor_status}, 32'h00);
    rate_lim = 32'd100;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 10);
    checkOutput("postrst_exempt", {31'd0, fault_rate}, 32'd0);
    checkOutput("postrst_width", last_width, 32'd5);
    checkOutput("postrst_status", {24'd0, monitor_status}, 32'h40);
    applyStimulus(1'b1, 5);
    checkOutput("postrst_rate", {31'd0, fault_rate}, 32'd1);
    applyStimulus(1'b0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
